// File: rtl/simd_pkg.sv
// Shared types and helpers for the SIMD unpack stream block.
package simd_pkg;

   // Operation codes; encoding 2'd3 is reserved and decoded as LO.
   typedef enum logic [1:0] {
      OP_LO   = 2'd0,
      OP_HI   = 2'd1,
      OP_BOTH = 2'd2
   } unpack_op_t;

   // Two-state beat sequencer.
   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StPendHi = 1'b1
   } unpack_state_t;

   // Element-mode encodings: element size = 8 << mode bits.
   localparam int unsigned MODE_8   = 0;
   localparam int unsigned MODE_16  = 1;
   localparam int unsigned MODE_32  = 2;
   localparam int unsigned MODE_64  = 3;
   localparam int unsigned MODE_128 = 4;

   // Element width in bits for a given mode value.
   function automatic int unsigned elem_bits(input int unsigned mode);
      return 32'd8 << mode;
   endfunction

endpackage

// File: rtl/simd_unpack_core.sv
// Combinational unpack interleaver: (A, B, mode, hi) -> interleaved data.
// LANE_W is the effective lane width; WIDTH/LANE_W lanes interleave independently.
module simd_unpack_core #(
   parameter int unsigned WIDTH  = 256,
   parameter int unsigned LANE_W = 256,
   parameter int unsigned MODE_W = 3
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [MODE_W-1:0] mode,
   input  logic              hi,
   output logic [WIDTH-1:0]  data
);

   // Modes with element size below the lane width interleave; larger ones pass A through.
   localparam int unsigned NUM_MODES = $clog2(LANE_W) - 3;
   localparam int unsigned NUM_LANES = WIDTH / LANE_W;

   logic [NUM_MODES-1:0][WIDTH-1:0] res_lo;
   logic [NUM_MODES-1:0][WIDTH-1:0] res_hi;

   for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
      localparam int unsigned E = 32'd8 << m;
      localparam int unsigned N = LANE_W / E;
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
         for (genvar i = 0; i < N / 2; i++) begin : g_elem
            assign res_lo[m][l*LANE_W + (2*i)*E   +: E] = b[l*LANE_W + i*E +: E];
            assign res_lo[m][l*LANE_W + (2*i+1)*E +: E] = a[l*LANE_W + i*E +: E];
            assign res_hi[m][l*LANE_W + (2*i)*E   +: E] = b[l*LANE_W + (i+N/2)*E +: E];
            assign res_hi[m][l*LANE_W + (2*i+1)*E +: E] = a[l*LANE_W + (i+N/2)*E +: E];
         end
      end
   end

   // Select the result for the active mode; anything unmatched is passthrough.
   always_comb begin
      data = a;
      for (int unsigned m = 0; m < NUM_MODES; m++) begin
         if (32'(mode) == m) begin
            data = hi ? res_hi[m] : res_lo[m];
         end
      end
   end

endmodule

// File: rtl/simd_unpack_stream.sv
// Registered, valid/ready SIMD unpack (UNPCKLO/UNPCKHI/BOTH) stage.
// Define SIMD_UNPACK_LANE_EN to interleave per LANE_W-bit lane (PUNPCKL/H style);
// otherwise one lane spans WIDTH.
module simd_unpack_stream
   import simd_pkg::*;
#(
   parameter int unsigned WIDTH  = 256,
   parameter int unsigned LANE_W = 128,
   parameter int unsigned MODE_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [MODE_W-1:0] in_mode,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_hi,
   output logic              out_last
);

`ifdef SIMD_UNPACK_LANE_EN
   localparam int unsigned LANE_BITS = LANE_W;
`else
   localparam int unsigned LANE_BITS = WIDTH;
`endif

   if (LANE_W < 16 || LANE_W > WIDTH || WIDTH < 16) begin : g_bad_param
      $error("simd_unpack_stream: illegal WIDTH/LANE_W combination");
   end

   unpack_state_t     state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [MODE_W-1:0] mode_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  out_data_q;
   logic              out_hi_q;
   logic              out_last_q;

   logic [WIDTH-1:0]  core_a;
   logic [WIDTH-1:0]  core_b;
   logic [MODE_W-1:0] core_mode;
   logic              core_hi;
   logic [WIDTH-1:0]  core_data;

   logic              accept;
   logic              op_hi;
   logic              op_both;
   logic              live_pass;

   // Reserved op 2'd3 falls through both decodes and behaves as LO.
   assign op_hi     = (in_op == OP_HI);
   assign op_both   = (in_op == OP_BOTH);
   assign live_pass = (elem_bits(32'(in_mode)) >= LANE_BITS);

   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Feed the core from live inputs in IDLE, from held operands for the pending HI beat.
   always_comb begin
      core_a    = in_a;
      core_b    = in_b;
      core_mode = in_mode;
      core_hi   = op_hi;
      if (state_q == StPendHi) begin
         core_a    = a_q;
         core_b    = b_q;
         core_mode = mode_q;
         core_hi   = 1'b1;
      end
   end

   simd_unpack_core #(
      .WIDTH  (WIDTH),
      .LANE_W (LANE_BITS),
      .MODE_W (MODE_W)
   ) u_core (
      .a    (core_a),
      .b    (core_b),
      .mode (core_mode),
      .hi   (core_hi),
      .data (core_data)
   );

   // Sequencer, operand hold and output register; output only changes on load or drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_hi_q    <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= core_data;
                  if (op_both && !live_pass) begin
                     out_hi_q   <= 1'b0;
                     out_last_q <= 1'b0;
                     a_q        <= in_a;
                     b_q        <= in_b;
                     mode_q     <= in_mode;
                     state_q    <= StPendHi;
                  end else begin
                     out_hi_q   <= op_hi;
                     out_last_q <= 1'b1;
                  end
               end else if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            StPendHi: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= core_data;
                  out_hi_q    <= 1'b1;
                  out_last_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_hi    = out_hi_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_simd_unpack_stream.sv
// Directed bench for simd_unpack_stream (WIDTH=256, LANE_W=128).
// A byte k = k, B byte k = 8'h80 + k. Inputs change and outputs are sampled on negedge.
module tb_simd_unpack_stream;

   localparam int unsigned WIDTH  = 256;
   localparam int unsigned LANE_W = 128;
   localparam int unsigned MODE_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a;
   logic [WIDTH-1:0]  in_b;
   logic [MODE_W-1:0] in_mode;
   logic [1:0]        in_op;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_hi;
   logic              out_last;

   logic [WIDTH-1:0]  a_vec;
   logic [WIDTH-1:0]  b_vec;
   logic [WIDTH-1:0]  held;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   simd_unpack_stream #(
      .WIDTH  (WIDTH),
      .LANE_W (LANE_W),
      .MODE_W (MODE_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_hi    (out_hi),
      .out_last  (out_last)
   );

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [MODE_W-1:0] mode, input logic [1:0] op);
      in_valid = 1'b1;
      in_a     = a_vec;
      in_b     = b_vec;
      in_mode  = mode;
      in_op    = op;
   endtask

   initial begin
      for (int k = 0; k < 32; k++) begin
         a_vec[k*8 +: 8] = 8'(k);
         b_vec[k*8 +: 8] = 8'(8'h80 + k);
      end
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = '0;
      in_op     = 2'd0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_hi", out_hi, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b1);

      // 1: mode0 LO
      present(3'd0, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_valid", out_valid, 1'b1);
      check("t1_lo16", out_data[15:0], 16'h0080);
`ifdef SIMD_UNPACK_LANE_EN
      check("t7_lane1", out_data[143:128], 16'h1090);
      check("t1_top16", out_data[255:240], 16'h1797);
`else
      check("t1_top16", out_data[255:240], 16'h0F8F);
`endif
      check("t1_last", out_last, 1'b1);
      check("t1_hi", out_hi, 1'b0);

      // 2: mode0 HI, accepted back-to-back while the LO beat drains
      present(3'd0, 2'd1);
      check("t2_btb_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check("t2_valid", out_valid, 1'b1);
`ifdef SIMD_UNPACK_LANE_EN
      check("t2_lo16", out_data[15:0], 16'h0888);
`else
      check("t2_lo16", out_data[15:0], 16'h1090);
`endif
      check("t2_top16", out_data[255:240], 16'h1F9F);
      check("t2_hi", out_hi, 1'b1);
      check("t2_last", out_last, 1'b1);
      @(negedge clk);
      check("t2_drained", out_valid, 1'b0);

      // 3: mode1 BOTH with continuous out_ready
      present(3'd1, 2'd2);
      @(negedge clk);
      in_valid = 1'b0;
      check("t3_lo_valid", out_valid, 1'b1);
      check("t3_lo32", out_data[31:0], 32'h0100_8180);
      check("t3_lo_last", out_last, 1'b0);
      check("t3_lo_hi", out_hi, 1'b0);
      check("t3_pend_ready", in_ready, 1'b0);
      @(negedge clk);
      check("t3_hi_valid", out_valid, 1'b1);
`ifdef SIMD_UNPACK_LANE_EN
      check("t3_hi32", out_data[31:0], 32'h0908_8988);
`else
      check("t3_hi32", out_data[31:0], 32'h1110_9190);
`endif
      check("t3_hi_last", out_last, 1'b1);
      check("t3_hi_hi", out_hi, 1'b1);
      @(negedge clk);
      check("t3_drained", out_valid, 1'b0);

      // 4: BOTH under backpressure, then drain+accept on the HI beat
      out_ready = 1'b0;
      present(3'd0, 2'd2);
      @(negedge clk);
      in_valid = 1'b0;
      held = out_data;
      check("t4_lo16", out_data[15:0], 16'h0080);
      for (int c = 0; c < 5; c++) begin
         check("t4_hold_data", out_data, held);
         check("t4_hold_last", out_last, 1'b0);
         check("t4_hold_ready", in_ready, 1'b0);
         check("t4_hold_valid", out_valid, 1'b1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_hi_hi", out_hi, 1'b1);
      check("t4_hi_last", out_last, 1'b1);
      check("t4_hi_ready", in_ready, 1'b1);
      present(3'd0, 2'd3);
      @(negedge clk);
      in_valid = 1'b0;
      check("t4_next_valid", out_valid, 1'b1);
      check("t4_next_hi", out_hi, 1'b0);
      check("t4_next_lo16", out_data[15:0], 16'h0080);
      @(negedge clk);

      // 5: wide-element modes
      present(3'd4, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
`ifdef SIMD_UNPACK_LANE_EN
      check("t5_m4", out_data, a_vec);
`else
      check("t5_m4", out_data, {a_vec[127:0], b_vec[127:0]});
`endif
      present(3'd5, 2'd2);
      @(negedge clk);
      in_valid = 1'b0;
      check("t5_m5_data", out_data, a_vec);
      check("t5_m5_last", out_last, 1'b1);
      check("t5_m5_ready", in_ready, 1'b1);
      @(negedge clk);
      check("t5_m5_single", out_valid, 1'b0);

      // 6: reset during the pending HI beat
      out_ready = 1'b0;
      present(3'd0, 2'd2);
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_pend_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", out_valid, 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      check("t6_ready", in_ready, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t6_no_hi", out_valid, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
